// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide, one radix-2 step per cycle.
// Divider compiled in only when MULDIV_DIV_EN is defined; otherwise div ops flag illegal.
module muldiv_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        startE,
  input  logic [2:0]  funct3E,
  input  logic [31:0] srcaE,
  input  logic [31:0] srcbE,
  input  logic        flushE,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        illegal
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opnd_q, opnd_d, result_q, result_d;
  logic        neg_q, neg_d, illegal_q, illegal_d;

  logic        is_div, sa, sb;
  logic [31:0] mag_a, mag_b;
  logic [32:0] sum;
  logic [63:0] mul_next, step, prod;
  logic [31:0] mul_res, fin_res;

  assign is_div = funct3E[2];
  assign sa     = srcaE[31] & (is_div ? ~funct3E[0] : funct3E[1:0] != 2'b11);
  assign sb     = srcbE[31] & (is_div ? ~funct3E[0] : ~funct3E[1]);
  assign mag_a  = sa ? -srcaE : srcaE;
  assign mag_b  = sb ? -srcbE : srcbE;

  // acc holds {hi, lo}: product high/multiplier for mul, remainder/quotient for div
  assign sum      = {1'b0, acc_q[63:32]} + {1'b0, acc_q[0] ? opnd_q : 32'd0};
  assign mul_next = {sum, acc_q[31:1]};
  assign prod     = neg_q ? -step : step;
  assign mul_res  = op_q[1:0] == 2'b00 ? prod[31:0] : prod[63:32];

`ifdef MULDIV_DIV_EN
  logic [32:0] trial, diff;
  logic [31:0] dsel, div_res, special;
  logic        ge, div_zero, div_ovf;
  assign trial    = {acc_q[63:32], acc_q[31]};
  assign diff     = trial - {1'b0, opnd_q};
  assign ge       = ~diff[32];
  assign step     = op_q[2] ? {ge ? diff[31:0] : trial[31:0], acc_q[30:0], ge} : mul_next;
  assign dsel     = op_q[1] ? step[63:32] : step[31:0];
  assign div_res  = neg_q ? -dsel : dsel;
  assign fin_res  = op_q[2] ? div_res : mul_res;
  assign div_zero = srcbE == 32'd0;
  assign div_ovf  = ~funct3E[0] & srcaE == 32'h8000_0000 & srcbE == 32'hFFFF_FFFF;
  assign special  = div_zero ? (funct3E[1] ? srcaE : 32'hFFFF_FFFF)
                             : (funct3E[1] ? 32'd0 : 32'h8000_0000);
`else
  assign step    = mul_next;
  assign fin_res = op_q[2] ? 32'd0 : mul_res;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    neg_d     = neg_q;
    illegal_d = illegal_q;
    result_d  = result_q;
    if (flushE) begin
      state_d = IDLE;
    end else if (state_q == IDLE) begin
      if (startE) begin
        state_d   = RUN;
        op_d      = funct3E;
        cnt_d     = 6'd0;
        illegal_d = 1'b0;
        neg_d     = is_div & funct3E[1] ? sa : sa ^ sb;
        opnd_d    = is_div ? mag_b : mag_a;
        acc_d     = {32'd0, is_div ? mag_a : mag_b};
`ifdef MULDIV_DIV_EN
        if (is_div & (div_zero | div_ovf)) begin
          state_d  = DONE;
          result_d = special;
        end
`else
        if (is_div) begin
          state_d   = DONE;
          illegal_d = 1'b1;
          result_d  = 32'd0;
        end
`endif
      end
    end else if (state_q == RUN) begin
      acc_d = step;
      cnt_d = cnt_q + 6'd1;
      if (cnt_q == 6'd31) begin
        state_d  = DONE;
        result_d = fin_res;
      end
    end else begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 6'd0;
      op_q      <= 3'd0;
      acc_q     <= 64'd0;
      opnd_q    <= 32'd0;
      neg_q     <= 1'b0;
      illegal_q <= 1'b0;
      result_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      neg_q     <= neg_d;
      illegal_q <= illegal_d;
      result_q  <= result_d;
    end
  end

  assign busy    = state_q == RUN;
  assign done    = state_q == DONE;
  assign illegal = done & illegal_q;
  assign result  = result_q;
endmodule
